// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: segment bit positions
// and the hex glyph table used by the nibble decoder.
package seven_seg_pkg;

   // Bit positions inside the 8-bit seg bus (active-high form)
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int DP_BIT = 7;

   // Glyphs for 0..9, A, b, C, d, E, F with bit 0 = segment a, bit 6 = segment g
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,
      7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C,
      7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] glyph_of(input logic [3:0] nibble);
      return GLYPH_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seven_seg_hex_dec.sv
// Purely combinational hex nibble to seven-segment glyph decoder.
module seven_seg_hex_dec
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   // Table lookup of the active-high glyph for the nibble
   always_comb begin
      segs = glyph_of(nibble);
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment display scanner with double-buffered digit data,
// optional leading-zero blanking and configurable output polarity.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blank_lz,
   output logic [7:0]                seg,
   output logic [NUM_DIGITS-1:0]     dig_sel,
   output logic                      frame_done
);

   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W  = $clog2(REFRESH_DIV);
   localparam int DATA_W = 4 * NUM_DIGITS;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [PRE_W-1:0]      prescale;
   logic [IDX_W-1:0]      digit_idx;
   logic                  slot_end;
   logic                  frame_wrap;

   logic [DATA_W-1:0]     pend_data;
   logic [NUM_DIGITS-1:0] pend_dp;
   logic                  pend_flag;
   logic [DATA_W-1:0]     disp_data;
   logic [NUM_DIGITS-1:0] disp_dp;

   logic [3:0]            cur_nibble;
   logic                  cur_dp;
   logic                  cur_blank;
   logic [6:0]            cur_glyph;

   logic [7:0]            seg_next;
   logic [NUM_DIGITS-1:0] dig_next;
   logic [7:0]            seg_q;
   logic [NUM_DIGITS-1:0] dig_q;

   // A slot ends on the prescaler terminal count; the frame wraps when the
   // last digit's slot ends. Both are gated by enable so a frozen scan
   // never reports a wrap.
   assign slot_end   = enable && (prescale == PRE_LAST);
   assign frame_wrap = slot_end && (digit_idx == IDX_LAST);
   assign frame_done = frame_wrap;

   // Prescaler and digit index: advance one digit per REFRESH_DIV enabled cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale  <= '0;
         digit_idx <= '0;
      end else if (enable) begin
         if (slot_end) begin
            prescale  <= '0;
            digit_idx <= frame_wrap ? '0 : digit_idx + IDX_W'(1);
         end else begin
            prescale <= prescale + PRE_W'(1);
         end
      end
   end

   // Double buffer: loads land in pending and are promoted only at a frame
   // wrap, so a frame is always drawn from one consistent snapshot. A load
   // that coincides with the wrap skips pending and goes straight to display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data <= '0;
         pend_dp   <= '0;
         pend_flag <= 1'b0;
         disp_data <= '0;
         disp_dp   <= '0;
      end else if (load && frame_wrap) begin
         disp_data <= data_in;
         disp_dp   <= dp_in;
         pend_flag <= 1'b0;
      end else if (load) begin
         pend_data <= data_in;
         pend_dp   <= dp_in;
         pend_flag <= 1'b1;
      end else if (frame_wrap && pend_flag) begin
         disp_data <= pend_data;
         disp_dp   <= pend_dp;
         pend_flag <= 1'b0;
      end
   end

   // Select the current digit's nibble and dp, and decide whether it is a
   // leading zero: every nibble from this digit upward is zero. Digit 0 is
   // always shown so an all-zero value still displays a single 0.
   always_comb begin
      cur_nibble = disp_data[{digit_idx, 2'b00} +: 4];
      cur_dp     = disp_dp[digit_idx];
      cur_blank  = blank_lz && (digit_idx != '0) &&
                   ((disp_data >> {digit_idx, 2'b00}) == '0);
   end

   seven_seg_hex_dec u_hex_dec (
      .nibble (cur_nibble),
      .segs   (cur_glyph)
   );

   // Next output pattern in active-high form; dark whenever the scan is off.
   // The dp bit is kept even on a blanked digit.
   always_comb begin
      seg_next = '0;
      dig_next = '0;
      if (enable) begin
         seg_next[DP_BIT]      = cur_dp;
         seg_next[SEG_G:SEG_A] = cur_blank ? 7'h00 : cur_glyph;
         dig_next              = NUM_DIGITS'(1) << digit_idx;
      end
   end

   // Output registers give a fixed one-cycle latency behind the digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= '0;
         dig_q <= '0;
      end else begin
         seg_q <= seg_next;
         dig_q <= dig_next;
      end
   end

   assign seg     = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign dig_sel = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;

endmodule
